// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
// A load-use hazard or a flush loads a bubble; forwarded operands feed the ALU and store path.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [3:0]  id_alu_control,
    input  logic        id_alu_src,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        id_branch,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic        memwb_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    output logic [31:0] store_data,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_branch
);

    localparam logic [3:0] ALU_ADD = 4'b0010;

    logic             valid_reg;
    logic [31:0]      pc_reg;
    logic [31:0]      imm_reg;
    logic [1:0][31:0] rs_data_reg;
    logic [1:0][4:0]  rs_reg;
    logic [4:0]       rd_reg;
    logic [3:0]       alu_control_reg;
    logic             alu_src_reg;
    logic             reg_write_reg;
    logic             mem_read_reg;
    logic             mem_write_reg;
    logic             mem_to_reg_reg;
    logic             branch_reg;

    logic [1:0][31:0] fwd;
    logic             bubble;

    // Both rs fields are compared regardless of format; an occasional false stall is accepted.
    assign stall  = ex_valid & ex_mem_read & id_valid & (rd_reg != 5'd0)
                  & ((rd_reg == id_rs1) | (rd_reg == id_rs2));
    assign bubble = flush | stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg       <= 1'b0;
            pc_reg          <= '0;
            imm_reg         <= '0;
            rs_data_reg     <= '0;
            rs_reg          <= '0;
            rd_reg          <= '0;
            alu_control_reg <= ALU_ADD;
            alu_src_reg     <= 1'b0;
            reg_write_reg   <= 1'b0;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_to_reg_reg  <= 1'b0;
            branch_reg      <= 1'b0;
        end else if (bubble) begin
            valid_reg       <= 1'b0;
            pc_reg          <= '0;
            imm_reg         <= '0;
            rs_data_reg     <= '0;
            rs_reg          <= '0;
            rd_reg          <= '0;
            alu_control_reg <= ALU_ADD;
            alu_src_reg     <= 1'b0;
            reg_write_reg   <= 1'b0;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_to_reg_reg  <= 1'b0;
            branch_reg      <= 1'b0;
        end else begin
            valid_reg       <= id_valid;
            pc_reg          <= id_pc;
            imm_reg         <= id_imm;
            rs_data_reg     <= {id_rs2_data, id_rs1_data};
            rs_reg          <= {id_rs2, id_rs1};
            rd_reg          <= id_rd;
            alu_control_reg <= id_alu_control;
            alu_src_reg     <= id_alu_src;
            reg_write_reg   <= id_reg_write;
            mem_read_reg    <= id_mem_read;
            mem_write_reg   <= id_mem_write;
            mem_to_reg_reg  <= id_mem_to_reg;
            branch_reg      <= id_branch;
        end
    end

    // Index 0 is rs1, index 1 is rs2; the younger EX/MEM result takes precedence.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic exmem_hit;
            logic memwb_hit;
            assign exmem_hit = exmem_reg_write & (exmem_rd != 5'd0) & (exmem_rd == rs_reg[gi]);
            assign memwb_hit = memwb_reg_write & (memwb_rd != 5'd0) & (memwb_rd == rs_reg[gi]);
            assign fwd[gi]   = exmem_hit ? exmem_result :
                               memwb_hit ? memwb_result : rs_data_reg[gi];
        end
    endgenerate

    assign alu_a      = fwd[0];
    assign alu_b      = alu_src_reg ? imm_reg : fwd[1];
    assign store_data = fwd[1];

    assign ex_valid      = valid_reg;
    assign alu_control   = alu_control_reg;
    assign ex_pc         = pc_reg;
    assign ex_imm        = imm_reg;
    assign ex_rd         = rd_reg;
    assign ex_reg_write  = valid_reg & reg_write_reg;
    assign ex_mem_read   = valid_reg & mem_read_reg;
    assign ex_mem_write  = valid_reg & mem_write_reg;
    assign ex_mem_to_reg = valid_reg & mem_to_reg_reg;
    assign ex_branch     = valid_reg & branch_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model of the EX-stage contents.
// Prints one line per transaction and a final summary.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_control;
    logic        flush, exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic [31:0] alu_a, alu_b, store_data, ex_pc, ex_imm;
    logic [3:0]  alu_control;
    logic [4:0]  ex_rd;

    int checks = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .flush(flush), .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_result(exmem_result),
        .memwb_result(memwb_result), .stall(stall), .ex_valid(ex_valid), .alu_a(alu_a),
        .alu_b(alu_b), .alu_control(alu_control), .store_data(store_data), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    // Model of the instruction currently held in EX.
    typedef struct {
        bit          valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        bit          src, rw, mr, mw, m2r, br;
    } ex_t;

    ex_t m;

    function automatic ex_t empty_state();
        ex_t s;
        s.valid = 0; s.pc = 0; s.rs1d = 0; s.rs2d = 0; s.imm = 0;
        s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.alu = 4'b0010;
        s.src = 0; s.rw = 0; s.mr = 0; s.mw = 0; s.m2r = 0; s.br = 0;
        return s;
    endfunction

    function automatic logic [31:0] fwd_val(logic [4:0] rs, logic [31:0] own);
        if (rs == 0) return own;
        if (exmem_reg_write && exmem_rd == rs) return exmem_result;
        if (memwb_reg_write && memwb_rd == rs) return memwb_result;
        return own;
    endfunction

    function automatic bit exp_stall();
        return m.valid && m.mr && id_valid && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [4:0] exp_ctl;
        #1;
        exp_ctl = m.valid ? {m.rw, m.mr, m.mw, m.m2r, m.br} : 5'd0;
        check("stall", 32'(stall), 32'(exp_stall()));
        check("ex_valid", 32'(ex_valid), 32'(m.valid));
        check("alu_a", alu_a, fwd_val(m.rs1, m.rs1d));
        check("alu_b", alu_b, m.src ? m.imm : fwd_val(m.rs2, m.rs2d));
        check("store_data", store_data, fwd_val(m.rs2, m.rs2d));
        check("alu_control", 32'(alu_control), 32'(m.alu));
        check("ex_pc", ex_pc, m.pc);
        check("ex_imm", ex_imm, m.imm);
        check("ex_rd", 32'(ex_rd), 32'(m.rd));
        check("ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}), 32'(exp_ctl));
        $display("t=%0t rst_n=%0b flush=%0b stall=%0b ex_valid=%0b ex_rd=%0d alu_a=%h alu_b=%h store=%h",
                 $time, rst_n, flush, stall, ex_valid, ex_rd, alu_a, alu_b, store_data);
    endtask

    task automatic tick();
        ex_t nxt;
        if (flush || exp_stall()) begin
            nxt = empty_state();
        end else begin
            nxt.valid = id_valid; nxt.pc = id_pc; nxt.rs1d = id_rs1_data; nxt.rs2d = id_rs2_data;
            nxt.imm = id_imm; nxt.rs1 = id_rs1; nxt.rs2 = id_rs2; nxt.rd = id_rd;
            nxt.alu = id_alu_control; nxt.src = id_alu_src; nxt.rw = id_reg_write;
            nxt.mr = id_mem_read; nxt.mw = id_mem_write; nxt.m2r = id_mem_to_reg; nxt.br = id_branch;
        end
        @(posedge clk);
        m = rst_n ? nxt : empty_state();
        #1;
    endtask

    task automatic rand_id();
        logic [3:0] ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        id_valid = ($urandom_range(0, 9) < 8);
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom_range(0, 7));
        id_alu_control = ops[$urandom_range(0, 5)];
        id_alu_src = 1'($urandom_range(0, 1)); id_reg_write = 1'($urandom_range(0, 1));
        id_mem_read = ($urandom_range(0, 9) < 3); id_mem_write = 1'($urandom_range(0, 1));
        id_mem_to_reg = 1'($urandom_range(0, 1)); id_branch = 1'($urandom_range(0, 1));
        flush = ($urandom_range(0, 9) == 0);
        exmem_reg_write = 1'($urandom_range(0, 1)); memwb_reg_write = 1'($urandom_range(0, 1));
        exmem_rd = 5'($urandom_range(0, 7)); memwb_rd = 5'($urandom_range(0, 7));
        exmem_result = $urandom; memwb_result = $urandom;
    endtask

    task automatic clear_all();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_control = 4'b0010;
        id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        id_mem_to_reg = 0; id_branch = 0; flush = 0;
        exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_result = 0; memwb_result = 0;
    endtask

    task automatic load_word(input logic [4:0] rd);
        clear_all();
        id_valid = 1; id_rs1 = 5'd1; id_rd = rd; id_mem_read = 1; id_reg_write = 1;
        id_mem_to_reg = 1; id_alu_src = 1; id_imm = 32'h4;
    endtask

    initial begin
        m = empty_state();
        clear_all();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        m = empty_state();

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            rand_id();
            check_all();
            check("rst_ex_valid", 32'(ex_valid), 32'd0);
            check("rst_reg_write", 32'(ex_reg_write), 32'd0);
            check("rst_alu_control", 32'(alu_control), 32'h2);
            check("rst_stall", 32'(stall), 32'd0);
            tick();
        end
        rst_n = 1'b1;

        // ADD x3 = x1 + x2.
        clear_all();
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_rs1_data = 5; id_rs2_data = 7;
        id_reg_write = 1;
        check_all(); tick();
        check_all();
        check("add_alu_a", alu_a, 32'd5);
        check("add_alu_b", alu_b, 32'd7);
        check("add_alu_control", 32'(alu_control), 32'h2);
        check("add_ex_rd", 32'(ex_rd), 32'd3);

        // Forwarding priority on rs1 = x4.
        clear_all();
        id_valid = 1; id_rs1 = 4; id_rs1_data = 32'h1111; id_rd = 8; id_reg_write = 1;
        check_all(); tick();
        clear_all();
        exmem_reg_write = 1; memwb_reg_write = 1; exmem_rd = 4; memwb_rd = 4;
        exmem_result = 32'hAAAA; memwb_result = 32'hBBBB;
        check_all(); check("fwd_exmem", alu_a, 32'hAAAA);
        exmem_reg_write = 0;
        check_all(); check("fwd_memwb", alu_a, 32'hBBBB);
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        check_all(); check("fwd_none", alu_a, 32'h1111);
        tick();

        // sw with immediate on alu_b and forwarded rs2 on store_data.
        clear_all();
        id_valid = 1; id_rs1 = 1; id_rs2 = 6; id_alu_src = 1; id_imm = 32'h10; id_mem_write = 1;
        check_all(); tick();
        clear_all();
        memwb_reg_write = 1; memwb_rd = 6; memwb_result = 32'h1234;
        check_all();
        check("sw_alu_b", alu_b, 32'h10);
        check("sw_store_data", store_data, 32'h1234);
        tick();

        // Load-use: lw x5, then add x7 = x5 + x2.
        load_word(5'd5);
        check_all(); tick();
        clear_all();
        id_valid = 1; id_rs1 = 5; id_rs2 = 2; id_rd = 7; id_reg_write = 1;
        check_all(); check("lu_stall", 32'(stall), 32'd1);
        tick();
        check_all();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
        check("lu_stall_drop", 32'(stall), 32'd0);
        tick();
        check_all();
        check("lu_captured_valid", 32'(ex_valid), 32'd1);
        check("lu_captured_rd", 32'(ex_rd), 32'd7);

        // Load to x0 never stalls.
        load_word(5'd0);
        check_all(); tick();
        clear_all();
        id_valid = 1; id_rs1 = 0; id_rd = 2;
        check_all(); check("x0_no_stall", 32'(stall), 32'd0);
        tick();

        // Flush during a load-use cycle.
        load_word(5'd5);
        check_all(); tick();
        clear_all();
        id_valid = 1; id_rs1 = 5; id_rd = 9; id_reg_write = 1; flush = 1;
        check_all(); check("fl_stall", 32'(stall), 32'd1);
        tick();
        clear_all();
        check_all(); check("fl_bubble", 32'(ex_valid), 32'd0);
        tick();
        check_all(); check("fl_no_leak", 32'(ex_valid), 32'd0);

        // Asynchronous reset while stalled.
        load_word(5'd9);
        check_all(); tick();
        clear_all();
        id_valid = 1; id_rs2 = 9; id_rd = 3;
        check_all(); check("ar_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        m = empty_state();
        check_all();
        check("ar_stall_drop", 32'(stall), 32'd0);
        check("ar_valid_drop", 32'(ex_valid), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_id();
            check_all();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
